// File: rtl/arm_mem_pkg.sv
// Shared encodings for the ARMv8 memory stage.
// Access sizes, fault codes and the memory-unit FSM states.
package arm_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] FLT_NONE  = 2'd0;
  localparam logic [1:0] FLT_ALIGN = 2'd1;
  localparam logic [1:0] FLT_BUS   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_FAULT
  } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 64-bit aligned data bus.
// Builds byte enables, replicated store data, load extraction, misalign.
module mem_lane_align
  import arm_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata_rep,
  output logic [63:0] rdata_ext,
  output logic        misalign
);

  logic [63:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    unique case (1'b1)
      (size == SZ_B): begin
        be        = 8'h01 << addr_lo;
        wdata_rep = {8{wdata[7:0]}};
        rdata_ext = {56'd0, shifted[7:0]};
      end
      (size == SZ_H): begin
        be        = 8'h03 << addr_lo;
        wdata_rep = {4{wdata[15:0]}};
        rdata_ext = {48'd0, shifted[15:0]};
        misalign  = addr_lo[0];
      end
      (size == SZ_W): begin
        be        = 8'h0f << addr_lo;
        wdata_rep = {2{wdata[31:0]}};
        rdata_ext = {32'd0, shifted[31:0]};
        misalign  = |addr_lo[1:0];
      end
      default: begin
        be        = 8'hff;
        wdata_rep = wdata;
        rdata_ext = shifted;
        misalign  = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: data-memory req/ack port, branch resolve, MEM/WB register.
// Stalls upstream while an access is outstanding.
module mem_access_unit
  import arm_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_branch,
  input  logic [1:0]  ex_size,
  input  logic [63:0] ex_pc,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_read_data_2,
  input  logic        ex_zero,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        pc_src,
  output logic [63:0] branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_fault,
  output logic [1:0]  wb_fault_code
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mau_state_e state, state_nx;

  logic [CW-1:0] wait_cnt;
  logic [63:0]   addr_q;
  logic [1:0]    size_q;
  logic [4:0]    rd_q;
  logic          regw_q;

  logic [1:0]  ln_size;
  logic [2:0]  ln_addr;
  logic [7:0]  ln_be;
  logic [63:0] ln_wdata;
  logic [63:0] ln_rdata;
  logic        ln_mis;

  logic mem_op, stall_c, req_c;
  logic acc_ok, acc_bad, alu_wb, done, tmo;

  // Lanes follow EX inputs while idle, the captured access otherwise
  assign ln_size = (state == ST_ACCESS) ? size_q : ex_size;
  assign ln_addr = (state == ST_ACCESS) ? addr_q[2:0]
                                        : ex_alu_result[2:0];

  mem_lane_align u_lane (
    .size      (ln_size),
    .addr_lo   (ln_addr),
    .wdata     (ex_read_data_2),
    .rdata     (dmem_rdata),
    .be        (ln_be),
    .wdata_rep (ln_wdata),
    .rdata_ext (ln_rdata),
    .misalign  (ln_mis)
  );

  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    req_c    = 1'b0;
    acc_ok   = 1'b0;
    acc_bad  = 1'b0;
    alu_wb   = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_op && ln_mis) begin
          acc_bad = 1'b1;
        end else if (mem_op) begin
          acc_ok   = 1'b1;
          stall_c  = 1'b1;
          state_nx = ST_ACCESS;
        end else if (ex_valid) begin
          alu_wb = 1'b1;
        end
      end
      ST_ACCESS: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          if (wait_cnt == CW'(TIMEOUT - 1)) begin
            tmo      = 1'b1;
            state_nx = ST_FAULT;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign stall         = stall_c & reset;
  assign dmem_req      = req_c;
  assign dmem_addr     = addr_q;
  assign pc_src        = ex_valid & ex_branch & ex_zero;
  assign branch_target = ex_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt      <= '0;
      addr_q        <= '0;
      size_q        <= SZ_B;
      rd_q          <= '0;
      regw_q        <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_wdata    <= '0;
      dmem_be       <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_fault      <= 1'b0;
      wb_fault_code <= FLT_NONE;
    end else begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_fault      <= 1'b0;
      wb_fault_code <= FLT_NONE;
      if (acc_ok) begin
        wait_cnt   <= '0;
        addr_q     <= ex_alu_result;
        size_q     <= ex_size;
        rd_q       <= ex_rd;
        regw_q     <= ex_reg_write & ~ex_mem_write;
        dmem_we    <= ex_mem_write;
        dmem_wdata <= ln_wdata;
        dmem_be    <= ln_be;
      end
      if (req_c && !dmem_ack) wait_cnt <= wait_cnt + 1'b1;
      if (acc_bad) begin
        wb_valid      <= 1'b1;
        wb_rd         <= ex_rd;
        wb_data       <= ex_alu_result;
        wb_fault      <= 1'b1;
        wb_fault_code <= FLT_ALIGN;
      end
      if (alu_wb) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= ex_reg_write;
        wb_rd        <= ex_rd;
        wb_data      <= ex_alu_result;
      end
      if (done) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= regw_q;
        wb_rd        <= rd_q;
        wb_data      <= dmem_we ? 64'd0 : ln_rdata;
      end
      if (tmo) begin
        wb_valid      <= 1'b1;
        wb_rd         <= rd_q;
        wb_data       <= addr_q;
        wb_fault      <= 1'b1;
        wb_fault_code <= FLT_BUS;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit.
// Driver pushes expected writebacks; a monitor pops on wb_valid.
module tb_mem_access_unit;
  import arm_mem_pkg::*;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_branch = 1'b0;
  logic [1:0]  ex_size = '0;
  logic [63:0] ex_pc = '0;
  logic [63:0] ex_alu_result = '0;
  logic [63:0] ex_read_data_2 = '0;
  logic        ex_zero = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        stall, pc_src;
  logic [63:0] branch_target;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [63:0] dmem_rdata = '0;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_fault;
  logic [1:0]  wb_fault_code;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_size(ex_size), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_read_data_2(ex_read_data_2),
    .ex_zero(ex_zero), .ex_rd(ex_rd),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_fault(wb_fault),
    .wb_fault_code(wb_fault_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fault;
    logic [1:0]  code;
    logic        regw;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_be(input int n, input int off);
    return 8'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [63:0] ref_rep(input logic [63:0] d,
                                          input int n);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] d,
                                           input int n, input int off);
    logic [63:0] s;
    s = d >> (8 * off);
    if (n < 8) s = s & ((64'd1 << (8 * n)) - 64'd1);
    return s;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_spurious: got wb_valid=1 expected none at %0t",
                 $time);
      end else begin
        e = sb.pop_front();
        chk("wb_fault", wb_fault, e.fault);
        chk("wb_fault_code", wb_fault_code, e.code);
        chk("wb_reg_write", wb_reg_write, e.regw);
        if (!e.fault) chk("wb_rd", wb_rd, e.rd);
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic alu_op(input logic br, input logic z,
                        input logic [63:0] pc, input logic [63:0] alu,
                        input logic [4:0] rd, input logic regw);
    @(posedge clock); #1;
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_branch = br; ex_zero = z; ex_pc = pc;
    ex_alu_result = alu; ex_rd = rd; ex_reg_write = regw;
    ex_size = 2'($urandom); dmem_ack = 1'($urandom);
    sb.push_back('{1'b0, FLT_NONE, regw, rd, alu, 1'b1});
    @(negedge clock);
    chk("pc_src", pc_src, br & z);
    chk("branch_target", branch_target, pc);
    chk("alu_stall", stall, 1'b0);
    chk("alu_req", dmem_req, 1'b0);
  endtask

  task automatic bubble();
    @(posedge clock); #1;
    ex_valid = 1'b0; ex_branch = 1'b1; ex_zero = 1'b1;
    ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
    dmem_ack = 1'($urandom);
    @(negedge clock);
    chk("bubble_pc_src", pc_src, 1'b0);
    chk("bubble_stall", stall, 1'b0);
  endtask

  task automatic mem_op(input logic rdf, input logic wrf,
                        input logic [1:0] sz, input logic [63:0] addr,
                        input logic [63:0] sd, input logic [4:0] rd,
                        input logic regw, input int delay,
                        input logic [63:0] rdata);
    int n, off, k;
    logic ack;
    n = 1 << sz;
    off = int'(addr[2:0]);
    @(posedge clock); #1;
    ex_valid = 1'b1; ex_mem_read = rdf; ex_mem_write = wrf;
    ex_branch = 1'b0; ex_size = sz; ex_alu_result = addr;
    ex_read_data_2 = sd; ex_rd = rd; ex_reg_write = regw;
    dmem_ack = 1'b0;
    if ((addr % 64'(n)) != 0) begin
      sb.push_back('{1'b1, FLT_ALIGN, 1'b0, rd, 64'd0, 1'b0});
      @(negedge clock);
      chk("mis_stall", stall, 1'b0);
      chk("mis_req", dmem_req, 1'b0);
      return;
    end
    if (delay < TMO)
      sb.push_back('{1'b0, FLT_NONE, wrf ? 1'b0 : regw, rd,
                     ref_load(rdata, n, off), !wrf});
    else
      sb.push_back('{1'b1, FLT_BUS, 1'b0, rd, 64'd0, 1'b0});
    @(negedge clock);
    chk("accept_stall", stall, 1'b1);
    chk("accept_req", dmem_req, 1'b0);
    k = 0;
    while (k < 200) begin
      @(posedge clock); #1;
      ack = (k == delay);
      dmem_ack = ack;
      dmem_rdata = ack ? rdata : {$urandom, $urandom};
      @(negedge clock);
      chk("req", dmem_req, 1'b1);
      chk("addr", dmem_addr, addr);
      chk("we", dmem_we, wrf);
      chk("be", dmem_be, ref_be(n, off));
      if (wrf) chk("wdata", dmem_wdata, ref_rep(sd, n));
      chk("access_stall", stall, !ack);
      if (ack || k == TMO - 1) break;
      k++;
    end
    if (delay >= TMO) begin
      @(posedge clock); #1;
      ex_valid = 1'b0; dmem_ack = 1'b1;
      @(negedge clock);
      chk("fault_req", dmem_req, 1'b0);
      chk("fault_stall", stall, 1'b0);
      chk("req_cycles", 64'(k + 1), 64'(TMO));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int sel, dly, kind;
    repeat (2) @(negedge clock);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_fault", wb_fault, 1'b0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_be", dmem_be, 8'd0);
    chk("rst_stall", stall, 1'b0);
    reset = 1'b1;

    mem_op(1, 0, SZ_D, 64'h100, 64'd0, 5'd7, 1'b1, 2,
           64'h1122334455667788);
    mem_op(0, 1, SZ_B, 64'h103, 64'h123456789abcdeab, 5'd3, 1'b1, 0,
           64'd0);
    mem_op(1, 0, SZ_H, 64'h105, 64'd0, 5'd4, 1'b1, 0, 64'd0);
    mem_op(1, 0, SZ_W, 64'h200, 64'd0, 5'd9, 1'b1, 99, 64'd0);
    mem_op(1, 0, SZ_W, 64'h204, 64'd0, 5'd10, 1'b1, TMO - 1,
           64'hcafef00d_deadbeef);
    mem_op(1, 1, SZ_H, 64'h10e, 64'h5555_0000_0000_a1b2, 5'd2, 1'b1, 1,
           64'd0);
    alu_op(1'b1, 1'b1, 64'h40, 64'h0, 5'd0, 1'b0);
    alu_op(1'b1, 1'b0, 64'h40, 64'h0, 5'd0, 1'b0);

    // reset while an access is outstanding
    @(posedge clock); #1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_branch = 1'b0; ex_size = SZ_W; ex_alu_result = 64'h300;
    ex_rd = 5'd11; ex_reg_write = 1'b1; dmem_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_rst_req", dmem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_req", dmem_req, 1'b0);
    chk("async_rst_stall", stall, 1'b0);
    chk("async_rst_wb", wb_valid, 1'b0);
    @(posedge clock); #1;
    ex_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    mem_op(1, 0, SZ_D, 64'h308, 64'd0, 5'd12, 1'b1, 1,
           64'h0123456789abcdef);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        alu_op(1'($urandom), 1'($urandom), {$urandom, $urandom},
               {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      end else if (sel == 2) begin
        bubble();
      end else begin
        sz = 2'($urandom);
        a = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0)
          a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
        dly = $urandom_range(0, 9);
        if (dly < 7)       dly = $urandom_range(0, 4);
        else if (dly == 7) dly = TMO - 1;
        else               dly = 99;
        kind = $urandom_range(0, 2);
        mem_op(kind != 1, kind != 0, sz, a, {$urandom, $urandom},
               5'($urandom), 1'($urandom), dly, {$urandom, $urandom});
      end
    end

    @(posedge clock); #1;
    ex_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage consumer of the EX/MEM pipeline register in the pipelined ARMv8 core. Takes the latched ALU result (address), store data, PC and zero flag. Drives a req/ack data-memory port with byte lanes, stalling the pipeline while an access is outstanding. Resolves conditional branches and produces the registered MEM/WB payload.

## Interface
- `TIMEOUT`, default 16: maximum cycles to wait for `dmem_ack` before raising a bus fault.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ex_valid` in 1: the EX/MEM entry is a real instruction.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_branch` in 1 each: control bits latched with the entry.
- `ex_size` in 2: access size, 0 = byte, 1 = half, 2 = word, 3 = dword.
- `ex_pc` in 64: branch target already computed in EX.
- `ex_alu_result` in 64: address, or the writeback value for non-memory ops.
- `ex_read_data_2` in 64: store data.
- `ex_zero` in 1: ALU zero flag.
- `ex_rd` in 5: destination register.
- `stall` out 1: freeze IF/ID/EX and the EX/MEM register.
- `pc_src` out 1: take the branch. `branch_target` out 64: the branch target.
- `dmem_req`, `dmem_we` out 1 each; `dmem_addr` out 64; `dmem_wdata` out 64; `dmem_be` out 8.
- `dmem_ack` in 1; `dmem_rdata` in 64 (aligned dword).
- `wb_valid`, `wb_reg_write` out 1 each; `wb_rd` out 5; `wb_data` out 64.
- `wb_fault` out 1; `wb_fault_code` out 2: 1 = misaligned, 2 = bus timeout.

## Operation
- The unit accepts a memory op when `ex_valid & (ex_mem_read | ex_mem_write)` and the FSM is in IDLE. `ex_mem_read & ex_mem_write` together counts as a write.
- Alignment check: the address must be a multiple of 2^`ex_size`.
  - Misaligned: no dmem request is issued. The next cycle shows `wb_valid=1`, `wb_fault=1`, code 1, `wb_reg_write=0`.
- FSM states are IDLE, ACCESS and FAULT.
- IDLE:
  - Aligned accept: capture addr, wdata, be, size, rd and reg_write into internal registers, then go to ACCESS.
  - Non-memory valid op: register a MEM/WB payload with `wb_data=ex_alu_result` in one cycle.
- ACCESS:
  - `dmem_req=1`. Address, data, `we` and `be` stay stable until ack.
  - On `dmem_ack`: go to IDLE and register writeback. For a load, `wb_data` is the lane of `dmem_rdata` selected by `addr[2:0]`, zero-extended per size. For a store, `wb_reg_write=0`.
  - A wait counter increments on each ACCESS cycle without ack. When it reaches `TIMEOUT-1` without ack, go to FAULT.
- FAULT: lasts one cycle. `dmem_req=0`; `wb_valid=1`, `wb_fault=1`, code 2, `wb_reg_write=0`; then go to IDLE.
- Store lanes: `dmem_wdata` is the low 2^size bytes of store data replicated across all 8 bytes. `dmem_be` is a mask of 2^size ones shifted left by `addr[2:0]`.
- Branch: `pc_src = ex_valid & ex_branch & ex_zero` and `branch_target = ex_pc`. Both are combinational and are not gated by `stall`.
- `wb_valid=0` in any cycle with no completion.

## Timing
- Reset forces these outputs to 0: all `wb_*`, all `dmem_*` outputs, and `stall`. It also forces state to IDLE and the wait counter to 0.
  - `pc_src` and `branch_target` are combinational from the inputs.
  - A reset during ACCESS drops `dmem_req` immediately, and the transaction is abandoned.
- `stall` is combinational. It is 1 in IDLE when an aligned memory op is being accepted, and 1 in ACCESS until the ack cycle; it is 0 in the ack cycle.
- Load latency: accept edge, then N cycles of `dmem_req`, then writeback on the edge where ack is sampled. If ack arrives in the first ACCESS cycle, the minimum is 2 cycles from accept to `wb_valid`.
- Non-memory op latency: 1 cycle, identical to a plain pipeline register.
- `dmem_ack` is ignored outside ACCESS.
- If ack arrives in the same cycle the timeout expires, ack wins.

## Structure
- Shared package `arm_mem_pkg` holds:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`;
  - fault codes `FLT_NONE`, `FLT_ALIGN`, `FLT_BUS`;
  - the FSM state enum.
- One sub-module, `mem_lane_align`, is combinational. It takes size, `addr[2:0]` and data, and produces be, the replicated write data, the extracted load data and the misalign flag. It is reused by the instruction-fetch side later.

## Test plan
- Dword load at address `0x100`, `dmem_ack` after 3 cycles, `rdata=0x1122334455667788`:
  - `stall` is 1 for 3 cycles;
  - then `wb_data=0x1122334455667788`, `wb_rd` as issued, `wb_reg_write=1`.
- Byte store at `0x103` with data `0xAB`: `dmem_be=0x08`, `dmem_wdata=0xABABABABABABABAB`, `dmem_we=1`; `wb_reg_write=0` on ack.
- Half load at `0x105` (misaligned): no `dmem_req`; the next cycle has `wb_fault=1`, code 1, `wb_reg_write=0`, and `stall` stays 0.
- Word load, `dmem_ack` never asserted, `TIMEOUT=16`: `dmem_req` is held for 16 cycles, then one FAULT cycle with code 2, then IDLE and `stall=0`.
- Branch with `ex_zero=1`, `ex_pc=0x40`: `pc_src=1` and `branch_target=0x40` in the same cycle. Repeat with `ex_zero=0`: `pc_src=0`.
- Reset asserted mid-ACCESS: `dmem_req` and `stall` go to 0 asynchronously. After release, a fresh load completes normally.
